// File: rtl/bitfusion_pkg.sv
// Shared definitions for the bit-fusion lane array: width codes, FSM state type
// and the element-width decode helper.
package bitfusion_pkg;

  localparam logic [2:0] W1 = 3'd0;
  localparam logic [2:0] W2 = 3'd1;
  localparam logic [2:0] W4 = 3'd2;
  localparam logic [2:0] W8 = 3'd3;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Element width in bits for a width code; codes wider than the lane clamp to max_w.
  function automatic int elem_width(input logic [2:0] code, input int max_w);
    int w;
    case (code)
      W1:      w = 1;
      W2:      w = 2;
      W4:      w = 4;
      W8:      w = 8;
      default: w = max_w;
    endcase
    if (w > max_w) w = max_w;
    return w;
  endfunction

endpackage

// File: rtl/bitfusion_lane.sv
// One bit-fusion lane: packed multiply-sum of the registered operands (S1) and
// the vector accumulator (S2). Saturating accumulate when BITFUSION_SAT_EN is defined.
module bitfusion_lane
  import bitfusion_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] act,
  input  logic [DATA_W-1:0] wgt,
  input  logic [2:0]        act_code,
  input  logic [2:0]        wgt_code,
  input  logic              act_signed,
  input  logic              wgt_signed,
  input  logic              vld_p1,
  input  logic              last_p1,
  output logic [ACC_W-1:0]  psum
);

  localparam int PW = 2 * DATA_W + 2;

  int iw, ww, mx, p;
  logic        [DATA_W-1:0] a_raw, a_msk, w_raw, w_msk;
  logic                     a_neg, w_neg;
  logic signed [DATA_W:0]   a_ext, w_ext;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  beat_sum;
  logic signed [ACC_W-1:0]  sum_p1;
  logic signed [ACC_W-1:0]  acc_p2;
  logic signed [ACC_W-1:0]  psum_p2;
  logic signed [ACC_W-1:0]  acc_next;

  // Elements are laid out at their own stride; only the first P slots carry products.
  always_comb begin
    iw       = elem_width(act_code, DATA_W);
    ww       = elem_width(wgt_code, DATA_W);
    mx       = (iw > ww) ? iw : ww;
    p        = DATA_W / mx;
    beat_sum = '0;
    a_raw    = '0;
    a_msk    = '0;
    w_raw    = '0;
    w_msk    = '0;
    a_neg    = 1'b0;
    w_neg    = 1'b0;
    a_ext    = '0;
    w_ext    = '0;
    prod     = '0;
    for (int k = 0; k < DATA_W; k++) begin
      a_raw = act >> (k * iw);
      w_raw = wgt >> (k * ww);
      a_msk = a_raw & DATA_W'((1 << iw) - 1);
      w_msk = w_raw & DATA_W'((1 << ww) - 1);
      a_neg = act_signed && ((a_msk & DATA_W'(1 << (iw - 1))) != '0);
      w_neg = wgt_signed && ((w_msk & DATA_W'(1 << (ww - 1))) != '0);
      a_ext = {1'b0, a_msk};
      w_ext = {1'b0, w_msk};
      if (a_neg) a_ext = a_ext - (DATA_W + 1)'(1 << iw);
      if (w_neg) w_ext = w_ext - (DATA_W + 1)'(1 << ww);
      prod = PW'(a_ext) * PW'(w_ext);
      if (k < p) beat_sum = beat_sum + ACC_W'(prod);
    end
  end

  // ---- S1: product/sum register ----
  always_ff @(posedge clk) begin
    sum_p1 <= beat_sum;
  end

`ifdef BITFUSION_SAT_EN
  logic                   clamp_p2;
  logic                   sat_hit;
  logic signed [ACC_W:0]  add_wide;

  function automatic logic signed [ACC_W-1:0] sat_clamp(input logic signed [ACC_W:0] s);
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  assign add_wide = (ACC_W + 1)'(acc_p2) + (ACC_W + 1)'(sum_p1);
  assign sat_hit  = add_wide[ACC_W] ^ add_wide[ACC_W-1];
  // Once a lane has clipped it stays pinned until the vector completes.
  assign acc_next = clamp_p2 ? acc_p2 : sat_clamp(add_wide);

  always_ff @(posedge clk) begin
    if (rst) begin
      clamp_p2 <= 1'b0;
    end else if (vld_p1) begin
      clamp_p2 <= last_p1 ? 1'b0 : (clamp_p2 | sat_hit);
    end
  end
`else
  assign acc_next = acc_p2 + sum_p1;
`endif

  // ---- S2: accumulate; psum loads and the accumulator clears together ----
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p2  <= '0;
      psum_p2 <= '0;
    end else if (vld_p1) begin
      if (last_p1) begin
        psum_p2 <= acc_next;
        acc_p2  <= '0;
      end else begin
        acc_p2  <= acc_next;
      end
    end
  end

  assign psum = psum_p2;

endmodule

// File: rtl/bitfusion_lane_array.sv
// NUM_LANES parallel bit-fusion lanes with valid/ready in/out handshakes.
// Optional macro BITFUSION_SAT_EN selects saturating accumulation in every lane.
module bitfusion_lane_array
  import bitfusion_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [NUM_LANES*DATA_W-1:0]  in_data,
  input  logic [NUM_LANES*DATA_W-1:0]  weight_data,
  input  logic [2:0]                   in_width,
  input  logic [2:0]                   weight_width,
  input  logic                         s_in,
  input  logic                         s_weight,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_LANES*ACC_W-1:0]   psum,
  output logic                         cfg_err
);

  localparam int LOG2_W = $clog2(DATA_W);

  state_t state_q, state_d;
  logic   accept, out_fire;
  logic   first_q;
  logic   bad_cfg;

  logic [2:0] cfg_icode, cfg_wcode;
  logic       cfg_si, cfg_sw;
  logic [2:0] cur_icode, cur_wcode;
  logic       cur_si, cur_sw;

  logic [NUM_LANES*DATA_W-1:0] act_p0, wgt_p0;
  logic [2:0]                  icode_p0, wcode_p0;
  logic                        si_p0, sw_p0, last_p0, vld_p0;
  logic                        vld_p1, last_p1;

  assign out_fire = out_valid && out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && in_last) state_d = HOLD;
      end
      HOLD: begin
        in_ready = out_fire;
        if (out_fire) state_d = (accept && in_last) ? HOLD : ACCUM;
      end
      default: state_d = ACCUM;
    endcase
    if (rst) in_ready = 1'b0;
  end

  // Config is taken from the first beat of a vector and held until its last beat.
  assign cur_icode = first_q ? in_width     : cfg_icode;
  assign cur_wcode = first_q ? weight_width : cfg_wcode;
  assign cur_si    = first_q ? s_in         : cfg_si;
  assign cur_sw    = first_q ? s_weight     : cfg_sw;
  assign bad_cfg   = (int'(in_width) > LOG2_W) || (int'(weight_width) > LOG2_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      first_q   <= 1'b1;
      cfg_err   <= 1'b0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p0  <= accept;
      vld_p1  <= vld_p0;
      if (accept) first_q <= in_last;
      if (accept && first_q && bad_cfg) cfg_err <= 1'b1;
      if (vld_p1 && last_p1) out_valid <= 1'b1;
      else if (out_fire)     out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && first_q) begin
      cfg_icode <= in_width;
      cfg_wcode <= weight_width;
      cfg_si    <= s_in;
      cfg_sw    <= s_weight;
    end
  end

  // ---- S0: input register ----
  always_ff @(posedge clk) begin
    if (accept) begin
      act_p0   <= in_data;
      wgt_p0   <= weight_data;
      icode_p0 <= cur_icode;
      wcode_p0 <= cur_wcode;
      si_p0    <= cur_si;
      sw_p0    <= cur_sw;
      last_p0  <= in_last;
    end
  end

  // ---- S1: tag travelling with the lane product registers ----
  always_ff @(posedge clk) begin
    last_p1 <= last_p0;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    bitfusion_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .act        (act_p0[i*DATA_W +: DATA_W]),
      .wgt        (wgt_p0[i*DATA_W +: DATA_W]),
      .act_code   (icode_p0),
      .wgt_code   (wcode_p0),
      .act_signed (si_p0),
      .wgt_signed (sw_p0),
      .vld_p1     (vld_p1),
      .last_p1    (last_p1),
      .psum       (psum[i*ACC_W +: ACC_W])
    );
  end

endmodule
